// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, branch/call/return redirect and a circular return-link stack.
// Optional `PC_SEQ_TRACE_EN` adds an instrCount output counting enabled cycles.
module pc_sequencer #(
  parameter int unsigned     WIDTH        = 64,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     SHIFT        = 2,
  parameter int unsigned     OFFSET_W     = 26,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         branchTaken,
  input  logic                         call,
  input  logic                         ret,
  input  logic [OFFSET_W-1:0]          branchOffset,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             nextPC,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stackEmpty,
  output logic                         stackFull,
`ifdef PC_SEQ_TRACE_EN
  output logic [WIDTH-1:0]             instrCount,
`endif
  output logic                         underflow
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] step_pc, target, ofs_ext;
  logic [PW-1:0]    top_q, top_d, top_inc, top_dec;
  logic [DW-1:0]    depth_q, depth_d;
  logic             under_q, under_d;
  logic             push;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign ofs_ext = {{(WIDTH - OFFSET_W){branchOffset[OFFSET_W-1]}}, branchOffset};
  assign step_pc = pc_q + WIDTH'(STEP);
  assign target  = pc_q + (ofs_ext << SHIFT);

  // top_q is the next free slot; the entry below it (mod DEPTH) is the top of stack.
  assign top_inc = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(DEPTH - 1) : top_q - PW'(1);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    depth_d = depth_q;
    under_d = under_q;
    push    = 1'b0;
    if (enable) begin
      if (ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_q[top_dec];
          top_d   = top_dec;
          depth_d = depth_q - DW'(1);
        end else begin
          pc_d    = step_pc;
          under_d = 1'b1;
        end
      end else if (call) begin
        // A push when full lands on the oldest slot, so depth saturates.
        push  = 1'b1;
        pc_d  = target;
        top_d = top_inc;
        if (depth_q != DW'(DEPTH)) depth_d = depth_q + DW'(1);
      end else if (branchTaken) begin
        pc_d = target;
      end else begin
        pc_d = step_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      depth_q <= '0;
      under_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      under_q <= under_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stack_q[top_q] <= step_pc;
  end

`ifdef PC_SEQ_TRACE_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instrCount = cnt_q;
`endif

  assign pc         = pc_q;
  assign nextPC     = step_pc;
  assign depth      = depth_q;
  assign stackEmpty = (depth_q == '0);
  assign stackFull  = (depth_q == DW'(DEPTH));
  assign underflow  = under_q;

endmodule
